// File: rtl/multdiv_if.sv
// Operand, control and result bundle for the iterative multiplier/divider.
interface multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (radix-4 Booth, 16 steps) / divide (restoring, 32 steps).
// Optional MULTDIV_FAST_DIV0_EN: divide-by-zero completes one edge after start.
module multdiv (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StMult, StDiv} state_t;

    state_t      r_state, w_state;
    logic [64:0] r_prod, w_prod;     // Booth {hi, lo, q-1}; divide uses [31:0] as dividend/quotient
    logic [31:0] r_mcand, w_mcand;   // multiplicand, or divisor magnitude
    logic [31:0] r_rem, w_rem;
    logic [5:0]  r_count, w_count;
    logic        r_neg, w_neg;
    logic        r_dexc, w_dexc;
    logic [31:0] r_result, w_result;
    logic        r_exc, w_exc;
    logic        r_rdy, w_rdy;

    logic [33:0] w_a34, w_a2, w_addend, w_sum;
    logic [64:0] w_booth;
    logic [32:0] w_rem_sh, w_diff;
    logic [31:0] w_quo, w_mag_a, w_mag_b;

    // Booth digit from the overlapping triple, accumulated in 34 bits so +/-2A cannot overflow
    always_comb begin
        w_a34 = {{2{r_mcand[31]}}, r_mcand};
        w_a2  = {w_a34[32:0], 1'b0};
        case (r_prod[2:0])
            3'b001, 3'b010: w_addend = w_a34;
            3'b011:         w_addend = w_a2;
            3'b100:         w_addend = -w_a2;
            3'b101, 3'b110: w_addend = -w_a34;
            default:        w_addend = '0;
        endcase
        w_sum   = {{2{r_prod[64]}}, r_prod[64:33]} + w_addend;
        w_booth = {w_sum, r_prod[32:2]};
    end

    always_comb begin
        w_rem_sh = {r_rem, r_prod[31]};
        w_diff   = w_rem_sh - {1'b0, r_mcand};
        w_quo    = r_neg ? -r_prod[31:0] : r_prod[31:0];
        w_mag_a  = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
        w_mag_b  = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;
    end

    always_comb begin
        w_state  = r_state;
        w_prod   = r_prod;
        w_mcand  = r_mcand;
        w_rem    = r_rem;
        w_count  = r_count;
        w_neg    = r_neg;
        w_dexc   = r_dexc;
        w_result = r_result;
        w_exc    = r_exc;
        w_rdy    = 1'b0;
        // A start in any state aborts whatever is running
        if (bus.ctrl_MULT) begin
            w_state = StMult;
            w_mcand = bus.data_operandA;
            w_prod  = {32'd0, bus.data_operandB, 1'b0};
            w_count = 6'd0;
        end else if (bus.ctrl_DIV) begin
            w_state = StDiv;
            w_mcand = w_mag_b;
            w_prod  = {33'd0, w_mag_a};
            w_rem   = '0;
            w_count = 6'd0;
            w_neg   = bus.data_operandA[31] ^ bus.data_operandB[31];
            w_dexc  = (bus.data_operandB == 32'd0) ||
                      (bus.data_operandA == 32'h8000_0000 && bus.data_operandB == 32'hFFFF_FFFF);
`ifdef MULTDIV_FAST_DIV0_EN
            if (bus.data_operandB == 32'd0) begin
                w_count = 6'd32;
            end
`endif
        end else begin
            case (r_state)
                StMult: begin
                    if (r_count == 6'd16) begin
                        w_result = r_prod[32:1];
                        w_exc    = !((&r_prod[64:32]) || !(|r_prod[64:32]));
                        w_rdy    = 1'b1;
                        w_state  = StIdle;
                    end else begin
                        w_prod  = w_booth;
                        w_count = r_count + 6'd1;
                    end
                end
                StDiv: begin
                    if (r_count == 6'd32) begin
                        w_result = r_dexc ? 32'd0 : w_quo;
                        w_exc    = r_dexc;
                        w_rdy    = 1'b1;
                        w_state  = StIdle;
                    end else begin
                        if (!w_diff[32]) begin
                            w_rem         = w_diff[31:0];
                            w_prod[31:0]  = {r_prod[30:0], 1'b1};
                        end else begin
                            w_rem         = w_rem_sh[31:0];
                            w_prod[31:0]  = {r_prod[30:0], 1'b0};
                        end
                        w_count = r_count + 6'd1;
                    end
                end
                default: w_state = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_rem    <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_dexc   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_prod   <= w_prod;
            r_mcand  <= w_mcand;
            r_rem    <= w_rem;
            r_count  <= w_count;
            r_neg    <= w_neg;
            r_dexc   <= w_dexc;
            r_result <= w_result;
            r_exc    <= w_exc;
            r_rdy    <= w_rdy;
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed cases plus random operands against an arithmetic model.
module tb_multdiv;
    logic clock;
    logic reset;
    multdiv_if bus ();

    multdiv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          nchecks = 0;
    int          nerr    = 0;
    logic [31:0] last_res = 32'd0;

`ifdef MULTDIV_FAST_DIV0_EN
    localparam int Div0Lat = 1;
`else
    localparam int Div0Lat = 33;
`endif

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
        longint p;
        int     q;
        if (is_mult) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[31:0];
            exc = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            q   = $signed(a) / $signed(b);
            res = q;
            exc = 1'b0;
        end
    endtask

    task automatic start_op(input bit mult, input bit div, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = mult;
        bus.ctrl_DIV      = div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [31:0] er,
                             input logic ee);
        int first  = -1;
        int pulses = 0;
        for (int k = 1; k <= lat + 2; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == 1 && lat > 1) check32({tag, " hold"}, bus.data_result, last_res);
        end
        check32({tag, " pulses"}, pulses, 1);
        check32({tag, " rdy_edge"}, first, lat);
        check32({tag, " result"}, bus.data_result, er);
        check32({tag, " exc"}, {31'd0, bus.data_exception}, {31'd0, ee});
        last_res = er;
    endtask

    task automatic run_op(input string tag, input bit is_mult, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] er;
        logic        ee;
        int          lat;
        model(is_mult, a, b, er, ee);
        lat = is_mult ? 17 : ((b == 32'd0) ? Div0Lat : 33);
        start_op(is_mult, !is_mult, a, b);
        wait_done(tag, lat, er, ee);
    endtask

    initial begin
        int quiet;
        logic [31:0] a, b;
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        #12;
        check32("reset result", bus.data_result, 32'd0);
        check32("reset exc", {31'd0, bus.data_exception}, 32'd0);
        check32("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("mul 7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD);
        run_op("mul ovf", 1'b1, 32'h0001_0000, 32'h0001_0000);
        run_op("mul min x -1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mul max x max", 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div 5/0", 1'b0, 32'd5, 32'd0);
        run_op("div min/1", 1'b0, 32'h8000_0000, 32'd1);
        run_op("div 7/-7", 1'b0, 32'd7, 32'hFFFF_FFF9);

        // Both strobes together: multiply takes precedence
        start_op(1'b1, 1'b1, 32'd6, 32'd7);
        wait_done("both ctrl", 17, 32'd42, 1'b0);

        // Restart: divide launched five edges into a multiply
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) quiet++;
        end
        check32("restart early rdy", quiet, 0);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        wait_done("restart div", 33, 32'd14, 1'b0);

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? ($urandom & 32'h0000_FFFF) : $urandom;
            run_op("rand mul", 1'b1, a, b);
        end
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case (i % 4)
                0:       b = $urandom_range(1, 15);
                1:       b = -$urandom_range(1, 300);
                2:       b = 32'd0;
                default: b = $urandom;
            endcase
            run_op("rand div", 1'b0, a, b);
        end

        // Reset in the middle of an operation clears outputs and suppresses RDY
        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check32("midreset result", bus.data_result, 32'd0);
        check32("midreset exc", {31'd0, bus.data_exception}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) quiet++;
        end
        check32("midreset no rdy", quiet, 0);
        last_res = 32'd0;
        run_op("post reset mul", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
